// File: rtl/fighter_fsm_if.sv
// Fighter control/status bundle: per-cycle actions and opponent state in, own position/lives/KO/hit out.
// The bench or arena logic holds the master side; the fighter itself is the slave.
interface fighter_fsm_if #(
    parameter int NUM_POS   = 3,
    parameter int MAX_LIVES = 3
) ();
    localparam int POS_W  = $clog2(NUM_POS + 1);
    localparam int LIFE_W = $clog2(MAX_LIVES + 1);

    logic              control;
    logic [2:0]        act_self;
    logic [2:0]        act_opp;
    logic [POS_W-1:0]  pos_opp;
    logic [LIFE_W-1:0] lives_opp;
    logic [POS_W-1:0]  pos;
    logic [LIFE_W-1:0] lives;
    logic              ko;
    logic              hit;

    modport master (
        output control, act_self, act_opp, pos_opp, lives_opp,
        input  pos, lives, ko, hit
    );

    modport slave (
        input  control, act_self, act_opp, pos_opp, lives_opp,
        output pos, lives, ko, hit
    );
endinterface

// File: rtl/fighter_fsm.sv
// Per-player fighter: registered position, lives, rest-heal counter, KO state and hit pulse.
// Optional macro FIGHTER_KNOCKBACK_EN: a landed kick also pushes the fighter back one position.
module fighter_fsm #(
    parameter int NUM_POS     = 3,
    parameter int MAX_LIVES   = 3,
    parameter int PUNCH_RANGE = 1,
    parameter int KICK_RANGE  = 2,
    parameter int REST_CYCLES = 2,
    parameter int SIDE        = 0
) (
    input  logic          clk,
    input  logic          reset,
    fighter_fsm_if.slave  bus
);
    localparam int POS_W  = $clog2(NUM_POS + 1);
    localparam int LIFE_W = $clog2(MAX_LIVES + 1);
    localparam int REST_W = $clog2(REST_CYCLES + 1);
    localparam int GAP_W  = $clog2(2 * NUM_POS + 2);

    localparam logic [2:0] ACT_KICK  = 3'b000;
    localparam logic [2:0] ACT_PUNCH = 3'b001;
    localparam logic [2:0] ACT_REST  = 3'b010;
    localparam logic [2:0] ACT_JUMP  = 3'b011;
    localparam logic [2:0] ACT_LEFT  = 3'b100;
    localparam logic [2:0] ACT_RIGHT = 3'b101;

    typedef enum logic {
        ST_FIGHT = 1'b0,
        ST_KO    = 1'b1
    } state_t;

    state_t            r_state;
    logic [POS_W-1:0]  r_pos;
    logic [LIFE_W-1:0] r_lives;
    logic [REST_W-1:0] r_rest;
    logic              r_hit;

    logic [GAP_W-1:0]  w_gap;
    logic              w_update;
    logic              w_fwd;
    logic              w_back;
    logic              w_kick_hit;
    logic              w_punch_hit;
    logic              w_hit;
    logic [POS_W-1:0]  w_pos_nx;
    logic [LIFE_W-1:0] w_lives_nx;
    logic [REST_W-1:0] w_rest_nx;
    logic              w_hit_nx;

    // Gap is measured edge-to-edge, so it uses our pre-move position and the opponent's current one.
    assign w_gap       = GAP_W'(2 * NUM_POS + 1) - GAP_W'(r_pos) - GAP_W'(bus.pos_opp);
    assign w_update    = bus.control && (r_lives != LIFE_W'(0)) && (bus.lives_opp != LIFE_W'(0));
    assign w_fwd       = (SIDE == 0) ? (bus.act_self == ACT_RIGHT) : (bus.act_self == ACT_LEFT);
    assign w_back      = (SIDE == 0) ? (bus.act_self == ACT_LEFT)  : (bus.act_self == ACT_RIGHT);
    assign w_kick_hit  = (bus.act_opp == ACT_KICK) && (int'(w_gap) <= KICK_RANGE)
                         && (bus.act_self != ACT_JUMP);
    assign w_punch_hit = (bus.act_opp == ACT_PUNCH) && (int'(w_gap) <= PUNCH_RANGE);
    assign w_hit       = w_kick_hit || w_punch_hit;

    // Next position, lives and rest count for one enabled update; everything holds otherwise.
    always_comb begin
        w_pos_nx   = r_pos;
        w_lives_nx = r_lives;
        w_rest_nx  = r_rest;
        w_hit_nx   = 1'b0;
        if (w_update) begin
`ifdef FIGHTER_KNOCKBACK_EN
            if (w_kick_hit) begin
                w_pos_nx = (r_pos > POS_W'(1)) ? (r_pos - POS_W'(1)) : r_pos;
            end else if (w_fwd && (r_pos < POS_W'(NUM_POS))) begin
                w_pos_nx = r_pos + POS_W'(1);
            end else if (w_back && (r_pos > POS_W'(1))) begin
                w_pos_nx = r_pos - POS_W'(1);
            end else begin
                w_pos_nx = r_pos;
            end
`else
            if (w_fwd && (r_pos < POS_W'(NUM_POS))) begin
                w_pos_nx = r_pos + POS_W'(1);
            end else if (w_back && (r_pos > POS_W'(1))) begin
                w_pos_nx = r_pos - POS_W'(1);
            end else begin
                w_pos_nx = r_pos;
            end
`endif
            if (w_hit) begin
                w_lives_nx = (r_lives != LIFE_W'(0)) ? (r_lives - LIFE_W'(1)) : r_lives;
                w_rest_nx  = REST_W'(0);
                w_hit_nx   = 1'b1;
            end else if (bus.act_self == ACT_REST) begin
                if (r_rest == REST_W'(REST_CYCLES - 1)) begin
                    w_rest_nx  = REST_W'(0);
                    w_lives_nx = (r_lives < LIFE_W'(MAX_LIVES)) ? (r_lives + LIFE_W'(1)) : r_lives;
                end else begin
                    w_rest_nx  = r_rest + REST_W'(1);
                    w_lives_nx = r_lives;
                end
            end else begin
                w_rest_nx = REST_W'(0);
            end
        end else begin
            w_hit_nx = 1'b0;
        end
    end

    // Fighter state register: KO is entered on the same edge lives reach zero and only reset leaves it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FIGHT;
            r_pos   <= POS_W'(1);
            r_lives <= LIFE_W'(MAX_LIVES);
            r_rest  <= REST_W'(0);
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                ST_FIGHT: r_state <= (w_lives_nx == LIFE_W'(0)) ? ST_KO : ST_FIGHT;
                ST_KO:    r_state <= ST_KO;
                default:  r_state <= ST_FIGHT;
            endcase
            r_pos   <= w_pos_nx;
            r_lives <= w_lives_nx;
            r_rest  <= w_rest_nx;
            r_hit   <= w_hit_nx;
        end
    end

    assign bus.pos   = r_pos;
    assign bus.lives = r_lives;
    assign bus.ko    = (r_state == ST_KO);
    assign bus.hit   = r_hit;
endmodule

// File: tb/tb_fighter_fsm.sv
// Directed bench for fighter_fsm (SIDE 0, 3 positions, 3 lives) with a per-cycle reference model.
module tb_fighter_fsm;
    localparam int NP = 3;
    localparam int ML = 3;
    localparam int PR = 1;
    localparam int KR = 2;
    localparam int RC = 2;

    localparam logic [2:0] KICK  = 3'd0;
    localparam logic [2:0] PUNCH = 3'd1;
    localparam logic [2:0] REST  = 3'd2;
    localparam logic [2:0] JUMP  = 3'd3;
    localparam logic [2:0] LEFT  = 3'd4;
    localparam logic [2:0] RIGHT = 3'd5;
    localparam logic [2:0] IDLE  = 3'd6;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fighter_fsm_if #(.NUM_POS(NP), .MAX_LIVES(ML)) bus ();

    fighter_fsm #(
        .NUM_POS(NP), .MAX_LIVES(ML), .PUNCH_RANGE(PR),
        .KICK_RANGE(KR), .REST_CYCLES(RC), .SIDE(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: arena rules in plain integer arithmetic.
    int m_pos, m_lives, m_rest, m_hit;
    always @(posedge clk or negedge reset) begin
        int gap, np;
        bit kick_l, punch_l;
        if (!reset) begin
            m_pos = 1; m_lives = ML; m_rest = 0; m_hit = 0;
        end else begin
            m_hit = 0;
            if (bus.control && m_lives > 0 && bus.lives_opp != 0) begin
                gap     = 2 * NP + 1 - m_pos - int'(bus.pos_opp);
                kick_l  = (bus.act_opp == KICK) && (gap <= KR) && (bus.act_self != JUMP);
                punch_l = (bus.act_opp == PUNCH) && (gap <= PR);
                np = m_pos;
                if (bus.act_self == RIGHT) np = (m_pos + 1 > NP) ? NP : m_pos + 1;
                if (bus.act_self == LEFT)  np = (m_pos - 1 < 1) ? 1 : m_pos - 1;
`ifdef FIGHTER_KNOCKBACK_EN
                if (kick_l) np = (m_pos - 1 < 1) ? 1 : m_pos - 1;
`endif
                if (kick_l || punch_l) begin
                    m_lives = m_lives - 1; m_rest = 0; m_hit = 1;
                end else if (bus.act_self == REST) begin
                    m_rest = m_rest + 1;
                    if (m_rest == RC) begin
                        m_rest = 0;
                        if (m_lives < ML) m_lives = m_lives + 1;
                    end
                end else begin
                    m_rest = 0;
                end
                m_pos = np;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("model_pos",   int'(bus.pos),   m_pos);
            chk("model_lives", int'(bus.lives), m_lives);
            chk("model_ko",    int'(bus.ko),    (m_lives == 0) ? 1 : 0);
            chk("model_hit",   int'(bus.hit),   m_hit);
        end
    end

    task automatic step(input logic ctl, input logic [2:0] as, input logic [2:0] ao);
        @(negedge clk);
        bus.control  = ctl;
        bus.act_self = as;
        bus.act_opp  = ao;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int p, input int l, input int k, input int h);
        chk({name, "_pos"},   int'(bus.pos),   p);
        chk({name, "_lives"}, int'(bus.lives), l);
        chk({name, "_ko"},    int'(bus.ko),    k);
        chk({name, "_hit"},   int'(bus.hit),   h);
    endtask

    initial begin
        int exp_r[4];
        int exp_l[3];
        exp_r = '{2, 3, 3, 3};
        exp_l = '{2, 1, 1};
        reset = 1'b0;
        bus.control = 1'b1; bus.act_self = IDLE; bus.act_opp = IDLE;
        bus.pos_opp = 2'd1; bus.lives_opp = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", 1, 3, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) step(1'b1, IDLE, IDLE);
        expect_out("idle5", 1, 3, 0, 0);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, RIGHT, IDLE);
            chk("walk_right", int'(bus.pos), exp_r[i]);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, LEFT, IDLE);
            chk("walk_left", int'(bus.pos), exp_l[i]);
        end
        step(1'b0, RIGHT, IDLE);
        chk("ctl_low_hold", int'(bus.pos), 1);

        // Close in to gap 1 and exercise dodge / punch / kick damage.
        repeat (2) step(1'b1, RIGHT, IDLE);
        bus.pos_opp = 2'd3;
        step(1'b1, JUMP, KICK);
        expect_out("jump_dodge", 3, 3, 0, 0);
        step(1'b1, JUMP, PUNCH);
        expect_out("punch_vs_jump", 3, 2, 0, 1);
        step(1'b1, IDLE, IDLE);
        chk("hit_one_cycle", int'(bus.hit), 0);
        step(1'b1, IDLE, KICK);
        chk("kick_lives", int'(bus.lives), 1);
        chk("kick_hit", int'(bus.hit), 1);

        // Rest heal, with control low in the middle of the count.
        step(1'b1, REST, IDLE);
        chk("rest1_lives", int'(bus.lives), 1);
        step(1'b1, REST, IDLE);
        chk("rest2_heal", int'(bus.lives), 2);
        step(1'b1, REST, IDLE);
        step(1'b0, REST, IDLE);
        chk("rest_held", int'(bus.lives), 2);
        step(1'b1, REST, IDLE);
        chk("rest_across_hold", int'(bus.lives), 3);
        repeat (2) step(1'b1, REST, IDLE);
        chk("rest_at_max", int'(bus.lives), 3);

        // Knock out with punches, then confirm the fighter is frozen.
        repeat (2) step(1'b1, RIGHT, IDLE);
        step(1'b1, IDLE, PUNCH);
        step(1'b1, IDLE, PUNCH);
        expect_out("ko_pre", 3, 1, 0, 1);
        step(1'b1, IDLE, PUNCH);
        expect_out("ko", 3, 0, 1, 1);
        step(1'b1, REST, KICK);
        step(1'b1, LEFT, PUNCH);
        expect_out("ko_frozen", 3, 0, 1, 0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        #2 reset = 1'b0;
        #1 expect_out("async_reset", 1, 3, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        bus.lives_opp = 2'd0;
        step(1'b1, RIGHT, IDLE);
        chk("opp_ko_freeze", int'(bus.pos), 1);
        bus.lives_opp = 2'd3;

        // Range boundaries at gap 2, then an interrupted heal.
        step(1'b1, RIGHT, IDLE);
        step(1'b1, IDLE, PUNCH);
        chk("punch_gap2_miss", int'(bus.lives), 3);
        step(1'b1, IDLE, KICK);
        chk("kick_gap2_land", int'(bus.lives), 2);
        step(1'b1, REST, IDLE);
        step(1'b1, IDLE, IDLE);
        step(1'b1, REST, IDLE);
        chk("rest_interrupted", int'(bus.lives), 2);
        step(1'b1, REST, IDLE);
        chk("rest_resumed", int'(bus.lives), 3);

        // Forward move against a kick, then backward move against a kick.
        repeat (2) step(1'b1, RIGHT, IDLE);
        step(1'b1, RIGHT, KICK);
`ifdef FIGHTER_KNOCKBACK_EN
        chk("fwd_kick_pos", int'(bus.pos), 2);
`else
        chk("fwd_kick_pos", int'(bus.pos), 3);
`endif
        chk("fwd_kick_lives", int'(bus.lives), 2);
        step(1'b1, LEFT, KICK);
`ifdef FIGHTER_KNOCKBACK_EN
        chk("back_kick_pos", int'(bus.pos), 1);
`else
        chk("back_kick_pos", int'(bus.pos), 2);
`endif
        chk("back_kick_lives", int'(bus.lives), 1);

        // Pseudo-random tail, checked by the model every cycle.
        for (int i = 0; i < 400; i++) begin
            if (m_lives == 0 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            bus.pos_opp   = 2'($urandom_range(1, NP));
            bus.lives_opp = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'd3;
            step(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fighter_fsm.md
# fighter_fsm

Parametrised per-player fighter state machine: registered position and life count for one fighter, updated once per enabled clock from its own action, the opponent's action, position and lives. One instance per player; the SIDE parameter sets which arena edge the fighter starts at. Adds configurable arena size, life count, attack ranges and heal time, a rest-counter heal, an explicit KO flag and a hit pulse.

## Interface
- NUM_POS, 3, positions per fighter, counted from its own edge, 1..NUM_POS (≥2)
- MAX_LIVES, 3, starting and maximum lives (≥1)
- PUNCH_RANGE, 1, largest gap at which a punch lands
- KICK_RANGE, 2, largest gap at which a kick lands (≥ PUNCH_RANGE)
- REST_CYCLES, 2, consecutive rest cycles needed to heal one life (≥1)
- SIDE, 0, 0 = left fighter (right = forward), 1 = right fighter (left = forward)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- control  input  1  update enable; low holds all state
- act_self  input  3  own action: 000 kick, 001 punch, 010 rest, 011 jump, 100 left, 101 right, 110/111 idle
- act_opp  input  3  opponent action, same encoding
- pos_opp  input  POS_W  opponent position (its own edge frame)
- lives_opp  input  LIFE_W  opponent lives
- pos  output  POS_W  own position, 1..NUM_POS
- lives  output  LIFE_W  own lives, 0..MAX_LIVES
- ko  output  1  high while lives == 0
- hit  output  1  one-cycle pulse: a life was lost on the last update
- POS_W = $clog2(NUM_POS+1), LIFE_W = $clog2(MAX_LIVES+1)

## Operation
- Gap = 2·NUM_POS + 1 − pos − pos_opp, computed from registered pos and current pos_opp; range 1..2·NUM_POS−1, fighters never overlap.
- Update happens when control = 1, lives ≠ 0 and lives_opp ≠ 0; otherwise pos, lives, rest counter held, hit = 0.
- Movement: forward = right if SIDE 0, left if SIDE 1. Forward: pos+1 if pos < NUM_POS, else hold. Backward: pos−1 if pos > 1, else hold.
- Damage (one per cycle max): opp kick and gap ≤ KICK_RANGE and act_self ≠ jump → hit; opp punch and gap ≤ PUNCH_RANGE → hit (jump does not dodge a punch). Hit: lives−1, saturating at 0.
- Heal: rest counter increments on each update cycle with act_self = rest and no hit; on reaching REST_CYCLES, lives+1 (saturate at MAX_LIVES, no change if already max) and counter clears. Any other action or any hit clears the counter. Held, not cleared, while control = 0.
- Simultaneous: own move and received hit in same cycle both apply; gap uses pre-move values. Heal and hit never coincide (hit wins, counter clears).
- lives reaching 0 sets ko next cycle edge; fighter frozen until reset.

## Timing
- All outputs registered; one-cycle latency from inputs sampled at rising clk to pos/lives/ko/hit.
- Reset (async assert, sync-to-clk effect on release): pos = 1, lives = MAX_LIVES, rest counter = 0, hit = 0, ko = 0.
- Reset mid-operation: immediate return to reset values regardless of control; pending rest count lost.
- hit high exactly one cycle per lost life; never high on a held cycle.
- ko = (lives == 0), registered alongside lives.

## Configuration
- FIGHTER_KNOCKBACK_EN defined: a kick hit also pushes the fighter back one position (pos−1 if pos > 1), overriding any own forward move that cycle; backward move plus knockback moves only one position.
- Undefined: kick hits change lives only; position follows own action alone.

## Test plan
- Reset with MAX_LIVES=3, NUM_POS=3 → pos=1, lives=3, ko=0, hit=0; release, 5 idle cycles → unchanged.
- SIDE=0, act_self=right 4 cycles → pos 2, 3, 3, 3; then left 3 cycles → 2, 1, 1.
- pos=3, pos_opp=3 (gap 1), act_opp=kick, act_self=jump → lives 3; act_self=idle → lives 2, hit pulse 1 cycle; act_opp=punch, act_self=jump → lives 1.
- lives=2, act_self=rest 2 cycles with control low 1 cycle between → lives 3 after second enabled rest; rest at lives=3 → stays 3, counter cleared.
- Three landed hits from lives=3 → lives 0, ko=1; further kicks and rest → no change, hit=0; lives_opp=0 also freezes a live fighter.
- FIGHTER_KNOCKBACK_EN defined, pos=3, act_self=right, opp kick at gap 1 → pos 2, lives 2; undefined → pos 3, lives 2.
